// File: rtl/exu_bjp_resolve.sv
// Branch/jump resolution: compares the IFU static prediction with the
// ALU outcome, raises a held flush with the corrected PC on a mispredict,
// hands a commit token to the commit stage and keeps saturating statistics.
module exu_bjp_resolve #(
    parameter int PC_SIZE = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bjp_i_valid,
    output logic               bjp_i_ready,
    input  logic [PC_SIZE-1:0] bjp_i_pc,
    input  logic               bjp_i_ilen32,
    input  logic               bjp_i_jal,
    input  logic               bjp_i_jalr,
    input  logic               bjp_i_bxx,
    input  logic               bjp_i_cmp_res,
    input  logic [PC_SIZE-1:0] bjp_i_tgt_pc,
    input  logic               bjp_i_prdt_taken,
    input  logic [PC_SIZE-1:0] bjp_i_prdt_pc,
    output logic               flush_req,
    output logic [PC_SIZE-1:0] flush_pc,
    input  logic               flush_ack,
    output logic               cmt_o_valid,
    output logic               cmt_o_mispred,
    input  logic               cmt_o_ready,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   bjp_cnt,
    output logic [CNT_W-1:0]   mispred_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic               cmt_pend_q;
    logic               cmt_pend_d;
    logic               fl_pend_q;
    logic               fl_pend_d;

    logic               accept;
    logic               act_taken;
    logic               mispred;
    logic [PC_SIZE-1:0] tgt_al;
    logic [PC_SIZE-1:0] seq_inc;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] corr_pc;

    logic               mispred_p1;
    logic [PC_SIZE-1:0] flush_pc_p1;
    logic [CNT_W-1:0]   bjp_cnt_q;
    logic [CNT_W-1:0]   mispred_cnt_q;

    assign bjp_i_ready = (state_q == S_IDLE);
    assign accept      = bjp_i_valid & bjp_i_ready;

    // Resolve the outcome and the corrected fetch PC from the presented fields.
    always_comb begin
        act_taken = bjp_i_jal | bjp_i_jalr | (bjp_i_bxx & bjp_i_cmp_res);
        tgt_al    = {bjp_i_tgt_pc[PC_SIZE-1:1], 1'b0};
        // Sequential PC wraps silently at the top of the address space.
        seq_inc   = bjp_i_ilen32 ? PC_SIZE'(4) : PC_SIZE'(2);
        seq_pc    = bjp_i_pc + seq_inc;
        corr_pc   = act_taken ? tgt_al : seq_pc;
        mispred   = (act_taken != bjp_i_prdt_taken) |
                    (act_taken & bjp_i_prdt_taken & (tgt_al != bjp_i_prdt_pc));
    end

    // Next-state logic: IDLE accepts one instruction, BUSY waits for both
    // the commit and (if needed) the flush handshake in any order.
    always_comb begin
        state_d    = state_q;
        cmt_pend_d = cmt_pend_q;
        fl_pend_d  = fl_pend_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_BUSY;
                    cmt_pend_d = 1'b1;
                    fl_pend_d  = mispred;
                end
            end
            S_BUSY: begin
                if (cmt_pend_q & cmt_o_ready) cmt_pend_d = 1'b0;
                if (fl_pend_q & flush_ack)    fl_pend_d  = 1'b0;
                if (!cmt_pend_d && !fl_pend_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and pending-flag registers; reset drops any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmt_pend_q <= 1'b0;
            fl_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmt_pend_q <= cmt_pend_d;
            fl_pend_q  <= fl_pend_d;
        end
    end

    // ---- stage p1: result captured on accept, held while BUSY ----
    // Capture mispredict flag and corrected PC so they stay stable during the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_p1  <= 1'b0;
            flush_pc_p1 <= '0;
        end else if (accept) begin
            mispred_p1  <= mispred;
            flush_pc_p1 <= corr_pc;
        end
    end

    // Saturating statistics; a clear beats a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bjp_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else if (stat_clr) begin
            bjp_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else if (accept) begin
            bjp_cnt_q <= sat_inc(bjp_cnt_q);
            if (mispred) mispred_cnt_q <= sat_inc(mispred_cnt_q);
        end
    end

    assign cmt_o_valid   = cmt_pend_q;
    assign flush_req     = fl_pend_q;
    assign cmt_o_mispred = mispred_p1;
    assign flush_pc      = flush_pc_p1;
    assign bjp_cnt       = bjp_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// Bench for exu_bjp_resolve: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
// A second instance with 3-bit counters exercises saturation cheaply.
module tb_exu_bjp_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bjp_i_valid = 1'b0;
    logic        bjp_i_ready;
    logic [31:0] bjp_i_pc = '0;
    logic        bjp_i_ilen32 = 1'b0;
    logic        bjp_i_jal = 1'b0;
    logic        bjp_i_jalr = 1'b0;
    logic        bjp_i_bxx = 1'b0;
    logic        bjp_i_cmp_res = 1'b0;
    logic [31:0] bjp_i_tgt_pc = '0;
    logic        bjp_i_prdt_taken = 1'b0;
    logic [31:0] bjp_i_prdt_pc = '0;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        flush_ack = 1'b0;
    logic        cmt_o_valid;
    logic        cmt_o_mispred;
    logic        cmt_o_ready = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] bjp_cnt;
    logic [15:0] mispred_cnt;

    logic        s_ready, s_flush_req, s_cmt_valid, s_cmt_mispred;
    logic [31:0] s_flush_pc;
    logic [2:0]  s_bjp_cnt, s_mispred_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int n_bjp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    exu_bjp_resolve #(.PC_SIZE(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .bjp_i_valid(bjp_i_valid), .bjp_i_ready(bjp_i_ready),
        .bjp_i_pc(bjp_i_pc), .bjp_i_ilen32(bjp_i_ilen32),
        .bjp_i_jal(bjp_i_jal), .bjp_i_jalr(bjp_i_jalr), .bjp_i_bxx(bjp_i_bxx),
        .bjp_i_cmp_res(bjp_i_cmp_res), .bjp_i_tgt_pc(bjp_i_tgt_pc),
        .bjp_i_prdt_taken(bjp_i_prdt_taken), .bjp_i_prdt_pc(bjp_i_prdt_pc),
        .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
        .cmt_o_valid(cmt_o_valid), .cmt_o_mispred(cmt_o_mispred),
        .cmt_o_ready(cmt_o_ready), .stat_clr(stat_clr),
        .bjp_cnt(bjp_cnt), .mispred_cnt(mispred_cnt)
    );

    exu_bjp_resolve #(.PC_SIZE(32), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst),
        .bjp_i_valid(bjp_i_valid), .bjp_i_ready(s_ready),
        .bjp_i_pc(bjp_i_pc), .bjp_i_ilen32(bjp_i_ilen32),
        .bjp_i_jal(bjp_i_jal), .bjp_i_jalr(bjp_i_jalr), .bjp_i_bxx(bjp_i_bxx),
        .bjp_i_cmp_res(bjp_i_cmp_res), .bjp_i_tgt_pc(bjp_i_tgt_pc),
        .bjp_i_prdt_taken(bjp_i_prdt_taken), .bjp_i_prdt_pc(bjp_i_prdt_pc),
        .flush_req(s_flush_req), .flush_pc(s_flush_pc), .flush_ack(flush_ack),
        .cmt_o_valid(s_cmt_valid), .cmt_o_mispred(s_cmt_mispred),
        .cmt_o_ready(cmt_o_ready), .stat_clr(stat_clr),
        .bjp_cnt(s_bjp_cnt), .mispred_cnt(s_mispred_cnt)
    );

    typedef struct {
        logic        jal, jalr, bxx, cmp;
        logic [31:0] pc;
        logic        il;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ppc;
        int          cdly, fdly;
        logic        exp_mis;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk_cnts(input string nm);
        chk({nm, " bjp_cnt"}, 64'(bjp_cnt), 64'(sat(n_bjp, 65535)));
        chk({nm, " mispred_cnt"}, 64'(mispred_cnt), 64'(sat(n_mis, 65535)));
        chk({nm, " bjp_cnt3"}, 64'(s_bjp_cnt), 64'(sat(n_bjp, 7)));
        chk({nm, " mispred_cnt3"}, 64'(s_mispred_cnt), 64'(sat(n_mis, 7)));
    endtask

    // One full transaction starting at a negedge with the unit idle.
    task automatic do_txn(input vec_t v, input logic clr, input string nm);
        logic pc_c, pf;
        chk({nm, " ready_before"}, 64'(bjp_i_ready), 64'(1));
        bjp_i_jal = v.jal; bjp_i_jalr = v.jalr; bjp_i_bxx = v.bxx;
        bjp_i_cmp_res = v.cmp; bjp_i_pc = v.pc; bjp_i_ilen32 = v.il;
        bjp_i_tgt_pc = v.tgt; bjp_i_prdt_taken = v.pt; bjp_i_prdt_pc = v.ppc;
        bjp_i_valid = 1'b1; stat_clr = clr; cmt_o_ready = 1'b0; flush_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        bjp_i_valid = 1'b0; stat_clr = 1'b0;
        if (clr) begin
            n_bjp = 0; n_mis = 0;
        end else begin
            n_bjp++;
            if (v.exp_mis) n_mis++;
        end
        chk_cnts(nm);
        chk({nm, " mispred"}, 64'(cmt_o_mispred), 64'(v.exp_mis));
        chk({nm, " flush_pc"}, 64'(flush_pc), 64'(v.exp_pc));
        chk({nm, " s_flush_pc"}, 64'(s_flush_pc), 64'(v.exp_pc));
        chk({nm, " s_mispred"}, 64'(s_cmt_mispred), 64'(v.exp_mis));
        pc_c = 1'b1;
        pf = v.exp_mis;
        for (int k = 0; k < 64 && (pc_c || pf); k++) begin
            chk({nm, " cmt_valid"}, 64'(cmt_o_valid), 64'(pc_c));
            chk({nm, " flush_req"}, 64'(flush_req), 64'(pf));
            chk({nm, " ready_busy"}, 64'(bjp_i_ready), 64'(0));
            chk({nm, " s_state"}, 64'({s_ready, s_cmt_valid, s_flush_req}), 64'({1'b0, pc_c, pf}));
            if (pf) chk({nm, " flush_pc_hold"}, 64'(flush_pc), 64'(v.exp_pc));
            cmt_o_ready = (k >= v.cdly);
            flush_ack = (k >= v.fdly);
            @(posedge clk); @(negedge clk);
            if (k >= v.cdly) pc_c = 1'b0;
            if (k >= v.fdly) pf = 1'b0;
        end
        cmt_o_ready = 1'b0; flush_ack = 1'b0;
        chk({nm, " ready_after"}, 64'(bjp_i_ready), 64'(1));
        chk({nm, " cmt_valid_after"}, 64'(cmt_o_valid), 64'(0));
        chk({nm, " flush_req_after"}, 64'(flush_req), 64'(0));
    endtask

    // Reference: outcome and correction computed straight from the rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic act;
        logic [31:0] tgt_al;
        r = v;
        act = v.jal | v.jalr | (v.bxx & v.cmp);
        tgt_al = v.tgt & 32'hFFFF_FFFE;
        r.exp_mis = (act != v.pt) || (act && v.pt && (tgt_al != v.ppc));
        r.exp_pc = act ? tgt_al : (v.pc + (v.il ? 32'd4 : 32'd2));
        return r;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //        jal   jalr  bxx   cmp   pc            il    tgt           pt    ppc           cd fd mis   exp_pc
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_00F0, 1'b1, 32'h0000_00F0, 0, 5, 1'b1, 32'h0000_0104};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_3001, 1'b1, 32'h0000_3000, 0, 0, 1'b0, 32'h0000_3000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_3001, 1'b1, 32'h0000_3004, 2, 0, 1'b1, 32'h0000_3000};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0010, 1, 1, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 1'b1, 32'h0000_0480, 1'b0, 32'h0000_0404, 4, 1, 1'b1, 32'h0000_0480};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0520, 1'b1, 32'h0000_0520, 3, 0, 1'b0, 32'h0000_0520};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 32'h0000_0700, 1'b0, 32'h0000_0602, 0, 2, 1'b0, 32'h0000_0602};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_07FC, 1'b1, 32'h0000_07F0, 1'b0, 32'h0000_0800, 0, 0, 1'b1, 32'h0000_07F0};

        // Reset release and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle ready", 64'(bjp_i_ready), 64'(1));
            chk("idle outs", 64'({flush_req, cmt_o_valid, cmt_o_mispred}), 64'(0));
            chk("idle flush_pc", 64'(flush_pc), 64'(0));
            chk_cnts("idle");
        end

        // Directed vector table
        for (int i = 0; i < 8; i++) do_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Clear while idle
        stat_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        stat_clr = 1'b0;
        n_bjp = 0; n_mis = 0;
        chk_cnts("clr_idle");

        // Saturation on the narrow instance, then clear coinciding with accept
        for (int i = 0; i < 9; i++) do_txn(vecs[7], 1'b0, $sformatf("sat%0d", i));
        chk("sat mispred3", 64'(s_mispred_cnt), 64'(7));
        do_txn(vecs[0], 1'b1, "clr_accept");
        chk("clr_accept bjp_cnt", 64'(bjp_cnt), 64'(0));

        // Reset while a flush and commit are pending
        v = vecs[0];
        bjp_i_jal = v.jal; bjp_i_jalr = v.jalr; bjp_i_bxx = v.bxx;
        bjp_i_cmp_res = v.cmp; bjp_i_pc = v.pc; bjp_i_ilen32 = v.il;
        bjp_i_tgt_pc = v.tgt; bjp_i_prdt_taken = v.pt; bjp_i_prdt_pc = v.ppc;
        bjp_i_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bjp_i_valid = 1'b0;
        chk("midrst pre flush_req", 64'(flush_req), 64'(1));
        rst = 1'b1;
        #1;
        n_bjp = 0; n_mis = 0;
        chk("midrst flush_req", 64'(flush_req), 64'(0));
        chk("midrst cmt_valid", 64'(cmt_o_valid), 64'(0));
        chk("midrst ready", 64'(bjp_i_ready), 64'(1));
        chk("midrst flush_pc", 64'(flush_pc), 64'(0));
        chk_cnts("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized transactions against the model
        for (int i = 0; i < 300; i++) begin
            int cls;
            cls = $urandom_range(0, 9);
            v.jal  = (cls == 0) || (cls == 9);
            v.jalr = (cls == 1);
            v.bxx  = (cls >= 2);
            if (cls == 9) v.jalr = $urandom_range(0, 1);
            v.cmp  = $urandom_range(0, 1);
            v.pc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            v.il   = $urandom_range(0, 1);
            v.tgt  = $urandom;
            v.pt   = $urandom_range(0, 1);
            v.ppc  = $urandom_range(0, 1) ? (v.tgt & 32'hFFFF_FFFE) : $urandom;
            v.cdly = $urandom_range(0, 4);
            v.fdly = $urandom_range(0, 4);
            v = model(v);
            do_txn(v, ($urandom_range(0, 19) == 0), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_bjp_resolve.md
# exu_bjp_resolve

Branch/jump resolution unit in the EXU. It is the back end of the IFU static-prediction path. It accepts each executed jal/jalr/bxx with the IFU's prediction (taken flag and predicted PC) and the ALU-computed outcome, and decides whether the prediction was wrong. On a misprediction it raises a held flush request carrying the corrected PC to the IFU. Independently it hands a commit token to the commit stage and keeps saturating prediction statistics.

## Interface
Parameters:
- PC_SIZE, 32, PC width (E203_PC_SIZE)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- bjp_i_valid  in  1  resolved branch/jump presented
- bjp_i_ready  out  1  unit can accept
- bjp_i_pc  in  PC_SIZE  PC of the branch instruction
- bjp_i_ilen32  in  1  1: 4-byte instruction, 0: 2-byte compressed
- bjp_i_jal / bjp_i_jalr / bjp_i_bxx  in  1 each  instruction class, one-hot
- bjp_i_cmp_res  in  1  bxx condition true
- bjp_i_tgt_pc  in  PC_SIZE  ALU target (pc+imm or rs1+imm)
- bjp_i_prdt_taken  in  1  IFU predicted taken
- bjp_i_prdt_pc  in  PC_SIZE  IFU predicted target
- flush_req  out  1  redirect request to IFU
- flush_pc  out  PC_SIZE  corrected fetch PC
- flush_ack  in  1  IFU accepts redirect
- cmt_o_valid  out  1  commit token valid
- cmt_o_mispred  out  1  token's instruction mispredicted
- cmt_o_ready  in  1  commit accepts token
- stat_clr  in  1  clear statistics counters
- bjp_cnt  out  CNT_W  branches/jumps resolved
- mispred_cnt  out  CNT_W  mispredictions

## Operation
- The handshake is accept = bjp_i_valid & bjp_i_ready. The unit captures all bjp_i_* fields on accept.
- Actual outcome: act_taken = jal | jalr | (bxx & cmp_res).
- A misprediction occurs when either condition holds:
  - act_taken != prdt_taken
  - act_taken & prdt_taken & (tgt_pc with bit0 cleared != prdt_pc)
- Corrected PC:
  - if act_taken: tgt_pc with bit0 forced to 0
  - otherwise: pc + (ilen32 ? 4 : 2), computed modulo 2^PC_SIZE so it wraps without a carry-out.
- The FSM has two states, IDLE and BUSY, with two pending flags, cmt_pend and fl_pend.
  - In IDLE, bjp_i_ready=1. On accept: go to BUSY, set cmt_pend=1, and set fl_pend to the misprediction result.
  - In BUSY, bjp_i_ready=0.
    - cmt_pend clears on cmt_o_valid & cmt_o_ready.
    - fl_pend clears on flush_req & flush_ack.
    - When both flags are clear (including both clearing in the same cycle), next state is IDLE.
- Output assignments: cmt_o_valid=cmt_pend, flush_req=fl_pend, cmt_o_mispred is the registered misprediction result, and flush_pc is the registered corrected PC.
- flush_pc holds its value while flush_req is high. Commit and flush complete in either order; each holds until its own handshake.
- Counters are updated on accept:
  - bjp_cnt increments by 1.
  - mispred_cnt increments by 1 when the accepted instruction mispredicts.
  - Both saturate at 2^CNT_W-1.
  - stat_clr zeroes both. If stat_clr coincides with an increment, the clear wins and the result is 0.
- Illegal class encodings (not one-hot) are not checked. The unit treats them via the same act_taken equation.

## Timing
- Reset values: state IDLE, bjp_i_ready=1, flush_req=0, cmt_o_valid=0, cmt_o_mispred=0, flush_pc=0, bjp_cnt=0, mispred_cnt=0.
- Reset asserted mid-operation drops any pending flush or commit immediately, with no handshake completion.
- Latency: accept in cycle N gives cmt_o_valid (and flush_req if mispredicted) high in cycle N+1.
- bjp_i_ready depends only on state, not combinationally on any input.
- Minimum spacing between accepts is 2 cycles: the ready/ack cycle followed by the IDLE accept cycle.
- Counter outputs reflect an accept in cycle N starting in cycle N+1.
- flush_req and cmt_o_valid are never deasserted without their handshake, except by reset.

## Test plan
- Reset release, then idle: all outputs at reset values; bjp_i_ready=1 held for 10 cycles.
- bxx at pc=0x100, ilen32=1, cmp_res=0, prdt_taken=1, tgt=0x0F0 -> cycle N+1: flush_req=1, flush_pc=0x104, cmt_o_mispred=1; mispred_cnt=1, bjp_cnt=1.
- jalr at pc=0x200, tgt=0x3001, prdt_taken=1, prdt_pc=0x3000 -> no flush, cmt_o_valid=1, cmt_o_mispred=0. Repeat with prdt_pc=0x3004 -> flush_pc=0x3000.
- Compressed bxx at pc=0xFFFFFFFE, not taken, predicted taken -> flush_pc=0x00000000 (wrap).
- Mispredict with flush_ack held low 5 cycles while cmt_o_ready=1 at N+1 -> cmt token completes, flush_req/flush_pc stable 6 cycles, bjp_i_ready=0 until the cycle after ack.
- Force mispred_cnt to 0xFFFF (CNT_W=16), then another mispredict -> stays 0xFFFF. stat_clr in the same cycle as an accept -> both counters 0.
